// File: rtl/srio_type9_arb.sv
// srio_type9_arb
// Two-input packet arbiter for packed SRIO type 9 streams feeding one
// shared AXI-Stream egress.
//
// Packets are granted whole. An arbitration cycle sits between packets,
// and contention is resolved round-robin against the port that finished
// most recently. Packets longer than MAX_WORDS are cut: the word at the
// limit leaves with TLAST set and the rest of the packet is discarded.
//
// Ports
//   AXIS_ACLK, AXIS_ARESET   clock, synchronous active-high reset
//   S0_AXIS_*                requester 0 stream (TDATA 64, TUSER 32)
//   S1_AXIS_*                requester 1 stream (TDATA 64, TUSER 32)
//   M_AXIS_*                 registered egress stream
//   ctrl                     bit0/bit1 enable port 0/1, bit2 clears status
//   stat_pkt0, stat_pkt1     packets forwarded per port (wrapping)
//   stat_trunc               packets truncated (wrapping)
//   err_trunc                sticky truncation flag
module srio_type9_arb #(
  parameter int MAX_WORDS = 33
) (
  input  logic        AXIS_ACLK,
  input  logic        AXIS_ARESET,
  input  logic [63:0] S0_AXIS_TDATA,
  input  logic        S0_AXIS_TLAST,
  input  logic [31:0] S0_AXIS_TUSER,
  input  logic        S0_AXIS_TVALID,
  output logic        S0_AXIS_TREADY,
  input  logic [63:0] S1_AXIS_TDATA,
  input  logic        S1_AXIS_TLAST,
  input  logic [31:0] S1_AXIS_TUSER,
  input  logic        S1_AXIS_TVALID,
  output logic        S1_AXIS_TREADY,
  output logic [63:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  output logic [31:0] M_AXIS_TUSER,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  input  logic [31:0] ctrl,
  output logic [15:0] stat_pkt0,
  output logic [15:0] stat_pkt1,
  output logic [15:0] stat_trunc,
  output logic        err_trunc
);

  typedef enum logic [2:0] {ARB, XFR0, XFR1, DRAIN0, DRAIN1} state_t;

  // Index of the last word a packet may contribute before being cut.
  localparam logic [7:0] LAST_IDX = 8'(MAX_WORDS - 1);

  state_t      state, state_nxt;
  logic        last_grant, last_grant_nxt;
  logic [7:0]  wcnt, wcnt_nxt;
  logic        out_rdy;
  logic        cand0, cand1;
  logic        sel1;
  logic        sel_valid, sel_last, sel_rdy, sel_fire;
  logic [63:0] sel_data;
  logic [31:0] sel_user;
  logic        at_max;
  logic        s0_rdy, s1_rdy;
  logic        load, inc_pkt, inc_trunc;
  logic        ctrl_unused;

  assign ctrl_unused = ^ctrl[31:3];

  assign out_rdy = !M_AXIS_TVALID | M_AXIS_TREADY;
  assign cand0   = S0_AXIS_TVALID & ctrl[0];
  assign cand1   = S1_AXIS_TVALID & ctrl[1];

  // Port 1 is the active source in XFR1/DRAIN1; everywhere else the mux
  // points at port 0, which is harmless because nothing fires in ARB.
  assign sel1      = (state == XFR1) || (state == DRAIN1);
  assign sel_valid = sel1 ? S1_AXIS_TVALID : S0_AXIS_TVALID;
  assign sel_last  = sel1 ? S1_AXIS_TLAST  : S0_AXIS_TLAST;
  assign sel_data  = sel1 ? S1_AXIS_TDATA  : S0_AXIS_TDATA;
  assign sel_user  = sel1 ? S1_AXIS_TUSER  : S0_AXIS_TUSER;
  assign at_max    = (wcnt == LAST_IDX);

  // Only the granted port ever sees TREADY. Draining ignores the egress
  // because discarded words never reach the output register.
  always_comb begin
    s0_rdy = 1'b0;
    s1_rdy = 1'b0;
    case (state)
      XFR0:    s0_rdy = out_rdy;
      XFR1:    s1_rdy = out_rdy;
      DRAIN0:  s0_rdy = 1'b1;
      DRAIN1:  s1_rdy = 1'b1;
      default: ;
    endcase
    if (AXIS_ARESET) begin
      s0_rdy = 1'b0;
      s1_rdy = 1'b0;
    end
  end

  assign S0_AXIS_TREADY = s0_rdy;
  assign S1_AXIS_TREADY = s1_rdy;
  assign sel_rdy        = sel1 ? s1_rdy : s0_rdy;
  assign sel_fire       = sel_valid & sel_rdy;

  // Next-state logic. A packet ends either on the source's TLAST or on the
  // word limit; the limit case also counts as a forwarded packet.
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    wcnt_nxt       = wcnt;
    load           = 1'b0;
    inc_pkt        = 1'b0;
    inc_trunc      = 1'b0;
    case (state)
      ARB: begin
        if (cand0 && cand1) begin
          state_nxt = last_grant ? XFR0 : XFR1;
        end else if (cand0) begin
          state_nxt = XFR0;
        end else if (cand1) begin
          state_nxt = XFR1;
        end
      end
      XFR0, XFR1: begin
        if (sel_fire) begin
          load = 1'b1;
          if (sel_last || at_max) begin
            wcnt_nxt       = 8'd0;
            last_grant_nxt = sel1;
            inc_pkt        = 1'b1;
            if (sel_last) begin
              state_nxt = ARB;
            end else begin
              inc_trunc = 1'b1;
              state_nxt = sel1 ? DRAIN1 : DRAIN0;
            end
          end else begin
            wcnt_nxt = wcnt + 8'd1;
          end
        end
      end
      DRAIN0, DRAIN1: begin
        if (sel_fire && sel_last) begin
          state_nxt = ARB;
        end
      end
      default: state_nxt = ARB;
    endcase
  end

  // Arbiter state. last_grant resets to 1 so port 0 wins the first tie.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state      <= ARB;
      last_grant <= 1'b1;
      wcnt       <= 8'd0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      wcnt       <= wcnt_nxt;
    end
  end

  // Egress register: a new word may replace the current one in the same
  // cycle it is consumed, so TVALID only falls when nothing is loaded.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TLAST  <= 1'b0;
      M_AXIS_TDATA  <= 64'd0;
      M_AXIS_TUSER  <= 32'd0;
    end else if (load) begin
      M_AXIS_TVALID <= 1'b1;
      M_AXIS_TLAST  <= sel_last | at_max;
      M_AXIS_TDATA  <= sel_data;
      M_AXIS_TUSER  <= sel_user;
    end else if (M_AXIS_TREADY) begin
      M_AXIS_TVALID <= 1'b0;
    end
  end

  // Status counters; the clear bit beats any increment in the same cycle.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET || ctrl[2]) begin
      stat_pkt0  <= 16'd0;
      stat_pkt1  <= 16'd0;
      stat_trunc <= 16'd0;
      err_trunc  <= 1'b0;
    end else begin
      if (inc_pkt && !sel1) begin
        stat_pkt0 <= stat_pkt0 + 16'd1;
      end
      if (inc_pkt && sel1) begin
        stat_pkt1 <= stat_pkt1 + 16'd1;
      end
      if (inc_trunc) begin
        stat_trunc <= stat_trunc + 16'd1;
        err_trunc  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_srio_type9_arb.sv
// tb_srio_type9_arb
// Directed bench for srio_type9_arb. Instance 0 uses the default word
// limit, instance 1 uses MAX_WORDS=4 for truncation. Source words are
// queued per port and driven as AXI-Stream; expected egress words are
// queued in grant order and compared as the egress handshakes.
module tb_srio_type9_arb;

  typedef struct packed {
    logic [63:0] data;
    logic [31:0] user;
    logic        last;
  } word_t;

  logic        AXIS_ACLK = 1'b0;
  logic        AXIS_ARESET;
  logic [63:0] s_data  [2][2];
  logic        s_last  [2][2];
  logic [31:0] s_user  [2][2];
  logic        s_valid [2][2];
  logic        s_ready [2][2];
  logic [63:0] m_data  [2];
  logic        m_last  [2];
  logic [31:0] m_user  [2];
  logic        m_valid [2];
  logic        m_ready [2];
  logic [31:0] ctrl_r  [2];
  logic [15:0] st_pkt0 [2];
  logic [15:0] st_pkt1 [2];
  logic [15:0] st_trunc[2];
  logic        err     [2];

  word_t src_q[2][2][$];
  word_t exp_q[2][$];
  bit    rdy_q[2][$];
  int    out_cyc[2][$];

  int    pass_cnt = 0;
  int    fail_cnt = 0;
  int    total    = 0;
  int    cyc      = 0;
  int    stall_cnt = 0;
  logic  stall_prev = 1'b0;
  word_t stall_word;

  always #5 AXIS_ACLK = ~AXIS_ACLK;

  srio_type9_arb dut0 (
    .AXIS_ACLK(AXIS_ACLK), .AXIS_ARESET(AXIS_ARESET),
    .S0_AXIS_TDATA(s_data[0][0]), .S0_AXIS_TLAST(s_last[0][0]),
    .S0_AXIS_TUSER(s_user[0][0]), .S0_AXIS_TVALID(s_valid[0][0]),
    .S0_AXIS_TREADY(s_ready[0][0]),
    .S1_AXIS_TDATA(s_data[0][1]), .S1_AXIS_TLAST(s_last[0][1]),
    .S1_AXIS_TUSER(s_user[0][1]), .S1_AXIS_TVALID(s_valid[0][1]),
    .S1_AXIS_TREADY(s_ready[0][1]),
    .M_AXIS_TDATA(m_data[0]), .M_AXIS_TLAST(m_last[0]),
    .M_AXIS_TUSER(m_user[0]), .M_AXIS_TVALID(m_valid[0]),
    .M_AXIS_TREADY(m_ready[0]),
    .ctrl(ctrl_r[0]), .stat_pkt0(st_pkt0[0]), .stat_pkt1(st_pkt1[0]),
    .stat_trunc(st_trunc[0]), .err_trunc(err[0])
  );

  srio_type9_arb #(.MAX_WORDS(4)) dut1 (
    .AXIS_ACLK(AXIS_ACLK), .AXIS_ARESET(AXIS_ARESET),
    .S0_AXIS_TDATA(s_data[1][0]), .S0_AXIS_TLAST(s_last[1][0]),
    .S0_AXIS_TUSER(s_user[1][0]), .S0_AXIS_TVALID(s_valid[1][0]),
    .S0_AXIS_TREADY(s_ready[1][0]),
    .S1_AXIS_TDATA(s_data[1][1]), .S1_AXIS_TLAST(s_last[1][1]),
    .S1_AXIS_TUSER(s_user[1][1]), .S1_AXIS_TVALID(s_valid[1][1]),
    .S1_AXIS_TREADY(s_ready[1][1]),
    .M_AXIS_TDATA(m_data[1]), .M_AXIS_TLAST(m_last[1]),
    .M_AXIS_TUSER(m_user[1]), .M_AXIS_TVALID(m_valid[1]),
    .M_AXIS_TREADY(m_ready[1]),
    .ctrl(ctrl_r[1]), .stat_pkt0(st_pkt0[1]), .stat_pkt1(st_pkt1[1]),
    .stat_trunc(st_trunc[1]), .err_trunc(err[1])
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic word_t mk_word(int p, logic [31:0] base, int i, int n);
    word_t w;
    w.data = {base, 32'(i)};
    w.user = {16'(p), base[15:0]};
    w.last = (i == n - 1);
    return w;
  endfunction

  task automatic drive_src();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (src_q[k][p].size() > 0) begin
          s_valid[k][p] = 1'b1;
          s_data[k][p]  = src_q[k][p][0].data;
          s_user[k][p]  = src_q[k][p][0].user;
          s_last[k][p]  = src_q[k][p][0].last;
        end else begin
          s_valid[k][p] = 1'b0;
          s_data[k][p]  = 64'd0;
          s_user[k][p]  = 32'd0;
          s_last[k][p]  = 1'b0;
        end
      end
    end
  endtask

  // Queue an n-word packet on port p of instance k and expect the first
  // nexp words (capped at the instance word limit) on the egress.
  task automatic applyStimulus(int k, int p, int n, logic [31:0] base,
                               int nexp, int maxw);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w = mk_word(p, base, i, n);
      src_q[k][p].push_back(w);
      if (i < nexp && i < maxw) begin
        w.last = w.last || (i == maxw - 1);
        exp_q[k].push_back(w);
      end
    end
    drive_src();
  endtask

  // One clock: sample handshakes mid-cycle, then advance sources and
  // the egress ready pattern just after the rising edge.
  task automatic cycle();
    logic f[2][2];
    word_t e;
    @(negedge AXIS_ACLK);
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) f[k][p] = s_valid[k][p] & s_ready[k][p];
      if (m_valid[k] && m_ready[k]) begin
        if (exp_q[k].size() == 0) begin
          checkOutput($sformatf("unexpected_out%0d", k), 128'(m_valid[k]), 128'd0);
        end else begin
          e = exp_q[k].pop_front();
          checkOutput($sformatf("out_word%0d", k),
                      {m_data[k], m_user[k], m_last[k]}, e);
          out_cyc[k].push_back(cyc);
        end
      end
    end
    if (stall_prev) begin
      checkOutput("stall_hold", {m_valid[0], m_data[0], m_user[0], m_last[0]},
                  {1'b1, stall_word});
    end
    stall_prev = m_valid[0] & !m_ready[0] & !AXIS_ARESET;
    if (stall_prev) begin
      stall_word = {m_data[0], m_user[0], m_last[0]};
      stall_cnt++;
      checkOutput("stall_sready", {s_ready[0][0], s_ready[0][1]}, 128'd0);
    end
    @(posedge AXIS_ACLK);
    cyc++;
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (f[k][p]) void'(src_q[k][p].pop_front());
      end
      m_ready[k] = (rdy_q[k].size() > 0) ? rdy_q[k].pop_front() : 1'b1;
    end
    drive_src();
  endtask

  function automatic bit is_idle(int k);
    return exp_q[k].size() == 0 && src_q[k][0].size() == 0 &&
           src_q[k][1].size() == 0 && !m_valid[k];
  endfunction

  task automatic run_idle(int k, string tag);
    int n = 0;
    while (!is_idle(k) && n < 200) begin
      cycle();
      n++;
    end
    checkOutput({"idle_", tag}, 128'(is_idle(k)), 128'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    word_t w;
    int guard;
    AXIS_ARESET = 1'b1;
    ctrl_r[0] = 32'h3;
    ctrl_r[1] = 32'h0;
    m_ready[0] = 1'b1;
    m_ready[1] = 1'b1;
    drive_src();

    // Reset with both ports already presenting a packet.
    applyStimulus(0, 0, 5, 32'hA000, 5, 33);
    applyStimulus(0, 1, 5, 32'hB000, 5, 33);
    repeat (3) cycle();
    checkOutput("rst_s0_ready", 128'(s_ready[0][0]), 128'd0);
    checkOutput("rst_s1_ready", 128'(s_ready[0][1]), 128'd0);
    for (int k = 0; k < 2; k++) begin
      checkOutput("rst_mvalid", 128'(m_valid[k]), 128'd0);
      checkOutput("rst_mlast", 128'(m_last[k]), 128'd0);
      checkOutput("rst_mdata", {m_data[k], m_user[k]}, 128'd0);
      checkOutput("rst_stats", {st_pkt0[k], st_pkt1[k], st_trunc[k], err[k]}, 128'd0);
    end

    // Simultaneous 5-word packets: port 0 first, one-cycle bubble, port 1.
    $display("[TB] simultaneous packets");
    AXIS_ARESET = 1'b0;
    out_cyc[0].delete();
    run_idle(0, "simul");
    checkOutput("simul_count", 128'(out_cyc[0].size()), 128'd10);
    if (out_cyc[0].size() == 10) begin
      checkOutput("simul_back2back", 128'(out_cyc[0][4] - out_cyc[0][0]), 128'd4);
      checkOutput("simul_bubble", 128'(out_cyc[0][5] - out_cyc[0][4]), 128'd2);
    end
    checkOutput("simul_pkt0", 128'(st_pkt0[0]), 128'd1);
    checkOutput("simul_pkt1", 128'(st_pkt1[0]), 128'd1);

    // Both ports continuously valid: grants alternate 0,1,0,1.
    $display("[TB] alternating grants");
    applyStimulus(0, 0, 3, 32'hC010, 3, 33);
    applyStimulus(0, 1, 3, 32'hC011, 3, 33);
    applyStimulus(0, 0, 3, 32'hC012, 3, 33);
    applyStimulus(0, 1, 3, 32'hC013, 3, 33);
    run_idle(0, "alt");
    checkOutput("alt_pkt0", 128'(st_pkt0[0]), 128'd3);
    checkOutput("alt_pkt1", 128'(st_pkt1[0]), 128'd3);

    // Egress back-pressure 1,0,0,1 during a 4-word packet.
    $display("[TB] egress stall");
    stall_cnt = 0;
    rdy_q[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    applyStimulus(0, 0, 4, 32'hD000, 4, 33);
    run_idle(0, "stall");
    checkOutput("stall_cycles", 128'(stall_cnt), 128'd2);
    checkOutput("stall_pkt0", 128'(st_pkt0[0]), 128'd4);

    // Port 1 disabled: no handshake, no output. Then clear the counters.
    $display("[TB] disabled port and clear");
    ctrl_r[0] = 32'h1;
    applyStimulus(0, 1, 2, 32'hE000, 0, 33);
    for (int i = 0; i < 5; i++) begin
      cycle();
      checkOutput("dis_s1_ready", 128'(s_ready[0][1]), 128'd0);
      checkOutput("dis_mvalid", 128'(m_valid[0]), 128'd0);
    end
    ctrl_r[0] = 32'h5;
    cycle();
    ctrl_r[0] = 32'h1;
    checkOutput("clr_stats", {st_pkt0[0], st_pkt1[0], st_trunc[0], err[0]}, 128'd0);
    ctrl_r[0] = 32'h3;
    for (int i = 0; i < 2; i++) begin
      w = mk_word(1, 32'hE000, i, 2);
      exp_q[0].push_back(w);
    end
    run_idle(0, "enable1");
    checkOutput("enable1_pkt1", 128'(st_pkt1[0]), 128'd1);

    // Reset while word 3 of a packet is pending: only words 1-2 appear.
    $display("[TB] reset mid-packet");
    applyStimulus(0, 0, 5, 32'hF000, 2, 33);
    guard = 0;
    while (src_q[0][0].size() > 3 && guard < 50) begin
      cycle();
      guard++;
    end
    checkOutput("midrst_at_w3", 128'(src_q[0][0].size()), 128'd3);
    AXIS_ARESET = 1'b1;
    cycle();
    checkOutput("midrst_mvalid", 128'(m_valid[0]), 128'd0);
    checkOutput("midrst_ready", {s_ready[0][0], s_ready[0][1]}, 128'd0);
    checkOutput("midrst_stats", {st_pkt0[0], st_pkt1[0], st_trunc[0], err[0]}, 128'd0);
    checkOutput("midrst_words_out", 128'(exp_q[0].size()), 128'd0);
    src_q[0][0].delete();
    drive_src();
    cycle();
    AXIS_ARESET = 1'b0;
    applyStimulus(0, 0, 2, 32'hF100, 2, 33);
    applyStimulus(0, 1, 2, 32'hF101, 2, 33);
    run_idle(0, "postrst");
    checkOutput("postrst_pkt0", 128'(st_pkt0[0]), 128'd1);

    // Word limit 4: a 6-word packet is cut after word 4, rest drained.
    $display("[TB] truncation");
    ctrl_r[1] = 32'h1;
    applyStimulus(1, 0, 6, 32'h7000, 6, 4);
    run_idle(1, "trunc");
    checkOutput("trunc_count", 128'(st_trunc[1]), 128'd1);
    checkOutput("trunc_err", 128'(err[1]), 128'd1);
    checkOutput("trunc_pkt0", 128'(st_pkt0[1]), 128'd1);
    applyStimulus(1, 0, 4, 32'h7100, 4, 4);
    run_idle(1, "exact");
    checkOutput("exact_trunc", 128'(st_trunc[1]), 128'd1);
    checkOutput("exact_pkt0", 128'(st_pkt0[1]), 128'd2);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
